// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM pipeline stage: req/ack data-memory access with upstream stall
// Optional access timeout enabled by defining DMEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int THREAD_BITS        = 2,
    parameter int DMEM_ADDR_WIDTH    = 10,
    parameter int TIMEOUT_CYCLES     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATAPATH_WIDTH-1:0]     alu_result_in,
    input  logic [DATAPATH_WIDTH-1:0]     store_data_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
    input  logic                          WR_en_in,
    input  logic                          mem_read_in,
    input  logic                          mem_write_in,
    input  logic [THREAD_BITS-1:0]        thread_id_in,
    output logic                          stall_out,
    output logic                          wb_en_out,
    output logic [DATAPATH_WIDTH-1:0]     accum_out,
    output logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out,
    output logic                          WR_en_out,
    output logic                          mem_reg_sel_out,
    output logic [THREAD_BITS-1:0]        thread_id_out,
    output logic                          err_out,
    output logic                          dmem_req,
    output logic                          dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0]    dmem_addr,
    output logic [DATAPATH_WIDTH-1:0]     dmem_wdata,
    input  logic [DATAPATH_WIDTH-1:0]     dmem_rdata,
    input  logic                          dmem_ack
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic                            dmem_req_q, dmem_req_d;
    logic                            dmem_we_q, dmem_we_d;
    logic [DMEM_ADDR_WIDTH-1:0]      dmem_addr_q, dmem_addr_d;
    logic [DATAPATH_WIDTH-1:0]       dmem_wdata_q, dmem_wdata_d;
    logic [DATAPATH_WIDTH-1:0]       held_alu_q, held_alu_d;
    logic [DATAPATH_WIDTH-1:0]       held_data_q, held_data_d;
    logic [REGFILE_ADDR_WIDTH-1:0]   held_wr_addr_q, held_wr_addr_d;
    logic                            held_wr_en_q, held_wr_en_d;
    logic                            held_read_q, held_read_d;
    logic [THREAD_BITS-1:0]          held_thread_q, held_thread_d;
    logic                            err_q, err_d;
    logic                            mem_op;
    logic                            timeout_hit;

    assign mem_op = in_valid & (mem_read_in | mem_write_in);

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        held_alu_d     = held_alu_q;
        held_data_d    = held_data_q;
        held_wr_addr_d = held_wr_addr_q;
        held_wr_en_d   = held_wr_en_q;
        held_read_d    = held_read_q;
        held_thread_d  = held_thread_q;
        err_d          = err_q;
`ifdef DMEM_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (mem_op) begin
                    held_alu_d     = alu_result_in;
                    held_wr_addr_d = WR_addr_in;
                    held_wr_en_d   = WR_en_in;
                    held_read_d    = mem_read_in;
                    held_thread_d  = thread_id_in;
                    dmem_req_d     = 1'b1;
                    // Read wins when both read and write are flagged.
                    dmem_we_d      = mem_write_in & ~mem_read_in;
                    dmem_addr_d    = alu_result_in[DMEM_ADDR_WIDTH+2:3];
                    dmem_wdata_d   = store_data_in;
                    state_d        = S_WAIT;
`ifdef DMEM_TIMEOUT_EN
                    wait_cnt_d     = '0;
`endif
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    if (held_read_q) held_data_d = dmem_rdata;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    state_d    = S_DONE;
                end else if (timeout_hit) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_DONE;
                end else begin
`ifdef DMEM_TIMEOUT_EN
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            held_alu_q     <= '0;
            held_data_q    <= '0;
            held_wr_addr_q <= '0;
            held_wr_en_q   <= 1'b0;
            held_read_q    <= 1'b0;
            held_thread_q  <= '0;
            err_q          <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            held_alu_q     <= held_alu_d;
            held_data_q    <= held_data_d;
            held_wr_addr_q <= held_wr_addr_d;
            held_wr_en_q   <= held_wr_en_d;
            held_read_q    <= held_read_d;
            held_thread_q  <= held_thread_d;
            err_q          <= err_d;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
`endif
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;

    // Handshake strobes are masked while reset is asserted so an abandoned access never hands off.
    always_comb begin
        stall_out       = 1'b0;
        wb_en_out       = 1'b0;
        accum_out       = alu_result_in;
        WR_addr_out     = WR_addr_in;
        WR_en_out       = 1'b0;
        mem_reg_sel_out = 1'b0;
        thread_id_out   = thread_id_in;
        err_out         = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        stall_out = 1'b1;
                    end else if (in_valid) begin
                        wb_en_out = 1'b1;
                        WR_en_out = WR_en_in;
                    end
                end
                S_WAIT: stall_out = 1'b1;
                default: begin
                    wb_en_out       = 1'b1;
                    accum_out       = (held_read_q && !err_q) ? held_data_q : held_alu_q;
                    WR_addr_out     = held_wr_addr_q;
                    WR_en_out       = held_wr_en_q & ~err_q;
                    mem_reg_sel_out = held_read_q;
                    thread_id_out   = held_thread_q;
                    err_out         = err_q;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-access stage sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. For loads and stores it runs a req/ack handshake with a variable-latency data memory and stalls the upstream pipeline until the access completes. Non-memory instructions pass through combinationally in the same cycle. It produces the accum/WR_addr/WR_en/mem_reg_sel/thread_id bundle plus an enable strobe for MEM/WB.

Parameters:
DATAPATH_WIDTH, 64, data/address word width
REGFILE_ADDR_WIDTH, 5, register-file address width
THREAD_BITS, 2, thread id width
DMEM_ADDR_WIDTH, 10, data-memory word-address width; must be <= DATAPATH_WIDTH-3
TIMEOUT_CYCLES, 16, WAIT-cycle limit, used only with DMEM_TIMEOUT_EN; must be >= 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  EX/MEM holds a valid instruction
alu_result_in  in  DATAPATH_WIDTH  ALU result; byte address for loads/stores
store_data_in  in  DATAPATH_WIDTH  store data
WR_addr_in  in  REGFILE_ADDR_WIDTH  destination register
WR_en_in  in  1  register write enable from decode
mem_read_in  in  1  load
mem_write_in  in  1  store
thread_id_in  in  THREAD_BITS  issuing thread
stall_out  out  1  hold EX/MEM and earlier stages
wb_en_out  out  1  enable for MEM/WB register
accum_out  out  DATAPATH_WIDTH  result to MEM/WB
WR_addr_out  out  REGFILE_ADDR_WIDTH  to MEM/WB
WR_en_out  out  1  to MEM/WB
mem_reg_sel_out  out  1  1 = accum carries load data
thread_id_out  out  THREAD_BITS  to MEM/WB
err_out  out  1  access-timeout flag
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = write, registered
dmem_addr  out  DMEM_ADDR_WIDTH  alu_result[DMEM_ADDR_WIDTH+2:3], registered
dmem_wdata  out  DATAPATH_WIDTH  registered
dmem_rdata  in  DATAPATH_WIDTH  read data, valid with dmem_ack
dmem_ack  in  1  access complete, single-cycle pulse

Behaviour:
- States: IDLE, WAIT, DONE. Reset sets state IDLE and clears dmem_req, dmem_we, dmem_addr, dmem_wdata, and all held registers (alu, data, WR_addr, WR_en, read, thread).
- Reset outputs: stall_out=0, wb_en_out=0, WR_en_out=0, err_out=0, with the remaining outputs following the !in_valid IDLE rules.
- mem_op = in_valid & (mem_read_in | mem_write_in). If both read and write are set, it is a load and the write is ignored.
- IDLE, !in_valid: wb_en_out=0, WR_en_out=0, stall_out=0.
- IDLE, in_valid & !mem_op: same-cycle passthrough. wb_en_out=1, accum_out=alu_result_in, mem_reg_sel_out=0, WR_addr/WR_en/thread_id pass through, stall_out=0.
- IDLE, mem_op:
  - Comb outputs: stall_out=1, wb_en_out=0.
  - At the clock edge: capture the instruction into held regs; set dmem_req=1, dmem_we=write & !read, and drive dmem_addr/dmem_wdata; go to WAIT.
- WAIT:
  - stall_out=1, wb_en_out=0; dmem_* stay stable.
  - On dmem_ack: capture dmem_rdata into held_data if the op is a load, clear dmem_req and dmem_we at that edge, go to DONE. An ack in the first WAIT cycle is legal.
- DONE:
  - Comb outputs: wb_en_out=1, stall_out=0, outputs driven from held regs. accum_out = held_read ? held_data : held_alu. mem_reg_sel_out=held_read. WR_en_out=held_WR_en.
  - Next state is IDLE. The EX/MEM inputs during DONE still show the completed instruction and are ignored.
- Latency: non-memory ops take 0 cycles. Memory ops take 2 + ack latency (minimum 3 cycles from IDLE to handoff).
- dmem_ack in IDLE or DONE is ignored.
- Reset mid-WAIT abandons the access: dmem_req drops at that edge, and no wb_en_out is produced for the instruction.

Optional Feature:
DMEM_TIMEOUT_EN
- Defined:
  - A WAIT-cycle counter clears on WAIT entry.
  - If TIMEOUT_CYCLES WAIT cycles elapse without ack, dmem_req drops and the block goes to DONE with an error flag set.
  - In that DONE cycle: err_out=1, WR_en_out=0, accum_out=held_alu.
  - Ack on the same cycle as the limit counts as success.
- Undefined: no counter; err_out is tied to 0 and WAIT waits indefinitely.

Test Plan:
- Reset, then in_valid=1, ALU op alu_result=0x55, WR_addr=3, WR_en=1 -> same cycle wb_en_out=1, accum_out=0x55, mem_reg_sel_out=0, stall_out=0.
- Load at addr 0x40, memory acks 1 cycle after req with rdata=0xDEAD -> dmem_addr=8, stall_out high for 2 cycles, then DONE with accum_out=0xDEAD, mem_reg_sel_out=1, wb_en_out=1 for exactly 1 cycle.
- Store at addr 0x18, data 0xBEEF, WR_en_in=0, ack after 5 cycles -> dmem_we=1, dmem_addr=3, dmem_wdata=0xBEEF held stable throughout WAIT; DONE with WR_en_out=0.
- Back-to-back: load then ALU op -> ALU op is handed off in the IDLE cycle immediately after DONE with its own thread_id; no duplicate wb_en_out.
- Reset asserted in WAIT, then a stray ack -> state IDLE, dmem_req=0 after the edge, no wb_en_out, ack ignored.
- With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> dmem_req drops after 16 WAIT cycles; err_out=1, WR_en_out=0, wb_en_out=1 for one cycle.
